// File: rtl/button_pkg.sv
// Shared types and helpers for the front-panel button conditioner.
package button_pkg;

    typedef enum logic [1:0] {
        EDGE_RISE,
        EDGE_FALL,
        EDGE_BOTH
    } edge_mode_t;

    typedef enum logic [1:0] {
        RELEASED,
        HOLD_WAIT,
        REPEAT,
        HELD
    } rep_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_event_channel.sv
// One button channel: synchronizer, stable-count debouncer, edge pulses and
// hold-to-auto-repeat generator. All outputs are registered.
//
// state     | meaning
// RELEASED  | button up, waiting for a debounced press
// HOLD_WAIT | pressed, counting down the initial repeat delay
// REPEAT    | pressed, emitting one pulse every repeat period
// HELD      | pressed with repeat disabled, silent until release
module btn_event_channel
    import button_pkg::*;
#(
    parameter int         SYNC_STAGES     = 2,
    parameter int         DEBOUNCE_CYCLES = 500000,
    parameter int         REPEAT_DELAY    = 50000000,
    parameter int         REPEAT_PERIOD   = 10000000,
    parameter edge_mode_t EDGE_MODE       = EDGE_RISE
) (
    input  logic clk,
    input  logic reset,
    input  logic in_signal,
    input  logic repeat_en,
    output logic level,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic repeat_pulse,
    output logic event_pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TMR_W = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMR_W-1:0] DELAY_LOAD  = TMR_W'(REPEAT_DELAY - 1);
    localparam logic [TMR_W-1:0] PERIOD_LOAD = TMR_W'(REPEAT_PERIOD - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       db_cnt;
    logic [TMR_W-1:0]       timer;
    rep_state_t             state;

    logic sync_out;
    logic accept;
    logic rise_evt;
    logic fall_evt;
    logic rep_fire;
    logic event_nxt;

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign accept   = (sync_out != level) && (db_cnt == CNT_LAST);
    assign rise_evt = accept && sync_out;
    assign fall_evt = accept && !sync_out;

    // A release landing on the same edge as an expiring timer wins over the repeat.
    assign rep_fire = ((state == HOLD_WAIT) || (state == REPEAT)) && repeat_en
                      && (timer == '0) && !fall_evt;

    always_comb begin
        event_nxt = 1'b0;
        case (EDGE_MODE)
            EDGE_RISE: event_nxt = rise_evt | rep_fire;
            EDGE_FALL: event_nxt = fall_evt;
            default:   event_nxt = rise_evt | fall_evt | rep_fire;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q       <= '0;
            db_cnt       <= '0;
            level        <= 1'b0;
            timer        <= '0;
            state        <= RELEASED;
            rise_pulse   <= 1'b0;
            fall_pulse   <= 1'b0;
            repeat_pulse <= 1'b0;
            event_pulse  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_signal};

            if ((sync_out == level) || accept) begin
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
            if (accept) begin
                level <= sync_out;
            end

            rise_pulse   <= rise_evt;
            fall_pulse   <= fall_evt;
            repeat_pulse <= rep_fire;
            event_pulse  <= event_nxt;

            case (state)
                RELEASED: begin
                    if (rise_evt) begin
                        state <= HOLD_WAIT;
                        timer <= DELAY_LOAD;
                    end
                end
                HOLD_WAIT, REPEAT: begin
                    if (fall_evt) begin
                        state <= RELEASED;
                    end else if (!repeat_en) begin
                        state <= HELD;
                    end else if (timer == '0) begin
                        state <= REPEAT;
                        timer <= PERIOD_LOAD;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                HELD: begin
                    if (fall_evt) begin
                        state <= RELEASED;
                    end
                end
                default: state <= RELEASED;
            endcase
        end
    end

endmodule

// File: rtl/button_event_detector.sv
// Multi-channel front-panel button conditioner: N_CH independent copies of
// the debounce / edge / auto-repeat channel.
module button_event_detector
    import button_pkg::*;
#(
    parameter int         N_CH            = 4,
    parameter int         SYNC_STAGES     = 2,
    parameter int         DEBOUNCE_CYCLES = 500000,
    parameter int         REPEAT_DELAY    = 50000000,
    parameter int         REPEAT_PERIOD   = 10000000,
    parameter edge_mode_t EDGE_MODE       = EDGE_RISE
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] in_signal,
    input  logic [N_CH-1:0] repeat_en,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] rise_pulse,
    output logic [N_CH-1:0] fall_pulse,
    output logic [N_CH-1:0] repeat_pulse,
    output logic [N_CH-1:0] event_pulse
);

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        btn_event_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
            .EDGE_MODE       (EDGE_MODE)
        ) u_chan (
            .clk          (clk),
            .reset        (reset),
            .in_signal    (in_signal[ch]),
            .repeat_en    (repeat_en[ch]),
            .level        (level[ch]),
            .rise_pulse   (rise_pulse[ch]),
            .fall_pulse   (fall_pulse[ch]),
            .repeat_pulse (repeat_pulse[ch]),
            .event_pulse  (event_pulse[ch])
        );
    end

endmodule
